sda_gmem_read_arbiter: RTL and testbench
========================================

SDA_GMEM_READ_ARBITER -- requirements
Module: sda_gmem_read_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, the gmem byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the gmem read data width.
REQ-003 SHALL have parameter ORDER_DEPTH, default 4, the maximum outstanding bursts; must be a power of two.
REQ-004 SHALL have port ap_clk, input, 1, the single clock for all logic.
REQ-005 SHALL have port ap_rst_n, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port sN_ARADDR (N=0,1), input, ADDR_WIDTH, the requester burst address.
REQ-007 SHALL have port sN_ARLEN, input, 8, the requester burst length minus one.
REQ-008 SHALL have port sN_ARVALID, input, 1; port sN_ARREADY, output, 1.
REQ-009 SHALL have port sN_RDATA, output, DATA_WIDTH; port sN_RRESP, output, 2; port sN_RLAST, output, 1.
REQ-010 SHALL have port sN_RVALID, output, 1; port sN_RREADY, input, 1.
REQ-011 SHALL have ports m_axi_gmem_ARADDR (output, ADDR_WIDTH), m_axi_gmem_ARLEN (output, 8), m_axi_gmem_ARVALID (output, 1) and m_axi_gmem_ARREADY (input, 1).
REQ-012 SHALL have ports m_axi_gmem_RDATA (input, DATA_WIDTH), m_axi_gmem_RRESP (input, 2), m_axi_gmem_RLAST (input, 1), m_axi_gmem_RVALID (input, 1) and m_axi_gmem_RREADY (output, 1).
REQ-013 SHALL have port busy, output, 1, asserted while any burst is pending or outstanding.

Function
REQ-014 AR stage SHALL use two states: IDLE, where it accepts one requester, and ISSUE, where m_axi_gmem_ARVALID=1 and the latched ARADDR/ARLEN are held stable.
REQ-015 In IDLE, the stage SHALL assert sN_ARREADY only to the granted requester, and only when the order FIFO is not full; in ISSUE, both sN_ARREADY SHALL be 0.
REQ-016 Grant SHALL be round-robin: if only one requester is valid, that requester wins; if both are valid, the requester not granted last wins; last_grant updates on every accept.
REQ-017 On a requester AR handshake, the stage SHALL register the address and length, push the requester index N into the order FIFO, and enter ISSUE; m_axi_gmem_ARVALID SHALL rise on the next cycle (latency 1).
REQ-018 ISSUE SHALL return to IDLE on the cycle m_axi_gmem_ARVALID and m_axi_gmem_ARREADY are both 1; back-to-back throughput SHALL be one AR per 2 cycles.
REQ-019 The order FIFO SHALL be ORDER_DEPTH entries of 1 bit, with a count of width log2(ORDER_DEPTH)+1 and wrap-around read/write pointers.
REQ-020 The FIFO SHALL pop on an m_axi_gmem_RVALID & m_axi_gmem_RREADY & m_axi_gmem_RLAST beat; a simultaneous push and pop SHALL leave the count unchanged.
REQ-021 R routing SHALL be combinational with zero latency: sN_RVALID = m_axi_gmem_RVALID & ~empty & (head==N).
REQ-022 m_axi_gmem_RREADY SHALL equal s[head]_RREADY & ~empty.
REQ-023 RDATA, RRESP and RLAST SHALL be broadcast to both requesters, qualified only by RVALID.
REQ-024 If m_axi_gmem_RVALID arrives while the FIFO is empty, m_axi_gmem_RREADY SHALL stay 0; the beat is never dropped or misrouted.
REQ-025 When the FIFO is full, no AR SHALL be accepted; acceptance SHALL resume on the cycle after the pop.
REQ-026 busy SHALL equal (count!=0) | m_axi_gmem_ARVALID.

Reset
REQ-027 ap_rst_n low SHALL immediately force: state IDLE; m_axi_gmem_ARVALID, sN_ARREADY and busy = 0; ARADDR/ARLEN = 0; FIFO pointers and count = 0; last_grant = 1 (requester 0 wins first).
REQ-028 Reset mid-burst SHALL discard all ordering state; the integrating wrapper resets the gmem fabric in the same domain.

Structure
REQ-029 The package sda_gmem_arb_pkg SHALL hold the state enumeration (IDLE, ISSUE) and the derived pointer-width constant.
REQ-030 The order FIFO SHALL be a single sub-module, sda_order_fifo (1-bit wide, parameterised depth), with push/pop/full/empty/head outputs.

Verification
REQ-031 Single request: s0 ARADDR=0x1000, ARLEN=3 -> one master AR with the same values one cycle later; 4 beats routed to s0; RLAST pops; busy falls the cycle after.
REQ-032 Contention: s0 and s1 both valid from reset -> grant order s0, s1, s0, s1 over 4 bursts; R bursts return to requesters in that order.
REQ-033 Full: ORDER_DEPTH=4 with ARREADY=1 and RVALID=0 -> 4 ARs accepted, 5th sN_ARREADY=0 until the first RLAST pop, then accepted next cycle.
REQ-034 Backpressure: m_axi_gmem_ARREADY held 0 for 10 cycles -> ARVALID/ARADDR stable, both sN_ARREADY=0; s1 RREADY=0 during its burst -> m_axi_gmem_RREADY=0, no beat lost.
REQ-035 Simultaneous push/pop and reset: accept and RLAST on the same cycle -> count unchanged; ap_rst_n low mid-burst -> all outputs 0 asynchronously, next request granted to s0.

Source files
------------

// File: rtl/sda_gmem_arb_pkg.sv
// Shared types and constants for the two-requester gmem read arbiter.
// Holds the AR stage state encoding and the order-FIFO pointer-width helper.
package sda_gmem_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } ar_state_e;

  localparam int unsigned ORDER_DEPTH_DEFAULT = 4;

  // A one-entry FIFO still needs a one-bit pointer.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned ORDER_PTR_W = ptr_width(ORDER_DEPTH_DEFAULT);
  localparam int unsigned ORDER_CNT_W = ORDER_PTR_W + 1;

endpackage

// File: rtl/sda_order_fifo.sv
// One-bit-wide order FIFO recording which requester owns each outstanding burst.
// Head is the owner of the burst whose R beats are currently returning.
module sda_order_fifo
  import sda_gmem_arb_pkg::*;
#(
  parameter  int unsigned DEPTH = ORDER_DEPTH_DEFAULT,
  localparam int unsigned PTR_W = ptr_width(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_push_id,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_head,
  output logic [CNT_W-1:0] o_count
);

  logic [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage is reset as well; it is only DEPTH bits and keeps o_head
      // a defined value even before the first push.
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_id;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/sda_gmem_read_arbiter.sv
// Round-robin arbiter merging two AXI read requesters onto one gmem master port.
// AR bursts are serialised through a two-state issue stage; R beats are steered back by burst order.
module sda_gmem_read_arbiter
  import sda_gmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ORDER_DEPTH = 4
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,

  input  logic [ADDR_WIDTH-1:0] s0_ARADDR,
  input  logic [7:0]            s0_ARLEN,
  input  logic                  s0_ARVALID,
  output logic                  s0_ARREADY,
  output logic [DATA_WIDTH-1:0] s0_RDATA,
  output logic [1:0]            s0_RRESP,
  output logic                  s0_RLAST,
  output logic                  s0_RVALID,
  input  logic                  s0_RREADY,

  input  logic [ADDR_WIDTH-1:0] s1_ARADDR,
  input  logic [7:0]            s1_ARLEN,
  input  logic                  s1_ARVALID,
  output logic                  s1_ARREADY,
  output logic [DATA_WIDTH-1:0] s1_RDATA,
  output logic [1:0]            s1_RRESP,
  output logic                  s1_RLAST,
  output logic                  s1_RVALID,
  input  logic                  s1_RREADY,

  output logic [ADDR_WIDTH-1:0] m_axi_gmem_ARADDR,
  output logic [7:0]            m_axi_gmem_ARLEN,
  output logic                  m_axi_gmem_ARVALID,
  input  logic                  m_axi_gmem_ARREADY,
  input  logic [DATA_WIDTH-1:0] m_axi_gmem_RDATA,
  input  logic [1:0]            m_axi_gmem_RRESP,
  input  logic                  m_axi_gmem_RLAST,
  input  logic                  m_axi_gmem_RVALID,
  output logic                  m_axi_gmem_RREADY,

  output logic                  busy
);

  localparam int unsigned CNT_W = ptr_width(ORDER_DEPTH) + 1;

  ar_state_e             r_state;
  ar_state_e             w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [7:0]            r_arlen;
  logic                  r_last_grant;

  logic                  w_grant;
  logic                  w_any_valid;
  logic                  w_accept;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_fifo_head;
  logic [CNT_W-1:0]      w_fifo_count;
  logic                  w_r_pop;

  // Round-robin: a lone requester always wins, a tie goes to the one not granted last.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it
    // unassigned and infer a latch.
    w_grant = 1'b0;
    if (s0_ARVALID && s1_ARVALID) begin
      w_grant = ~r_last_grant;
    end else if (s1_ARVALID) begin
      w_grant = 1'b1;
    end
  end

  assign w_any_valid = s0_ARVALID | s1_ARVALID;
  assign w_accept    = (r_state == IDLE) & ~w_fifo_full & w_any_valid;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = ISSUE;
      ISSUE:   if (m_axi_gmem_ARREADY) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ap_rst_n gates the requester readies so they drop the instant reset asserts,
  // even while a requester holds ARVALID high through reset.
  always_comb begin
    m_axi_gmem_ARVALID = 1'b0;
    s0_ARREADY         = 1'b0;
    s1_ARREADY         = 1'b0;
    case (r_state)
      IDLE: begin
        s0_ARREADY = w_accept & ~w_grant & ap_rst_n;
        s1_ARREADY = w_accept &  w_grant & ap_rst_n;
      end
      ISSUE:   m_axi_gmem_ARVALID = 1'b1;
      default: m_axi_gmem_ARVALID = 1'b0;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_araddr     <= '0;
      r_arlen      <= '0;
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_araddr     <= w_grant ? s1_ARADDR : s0_ARADDR;
      r_arlen      <= w_grant ? s1_ARLEN  : s0_ARLEN;
      r_last_grant <= w_grant;
    end
  end

  assign m_axi_gmem_ARADDR = r_araddr;
  assign m_axi_gmem_ARLEN  = r_arlen;

  sda_order_fifo #(
    .DEPTH (ORDER_DEPTH)
  ) u_order_fifo (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .i_push    (w_accept),
    .i_push_id (w_grant),
    .i_pop     (w_r_pop),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_head    (w_fifo_head),
    .o_count   (w_fifo_count)
  );

  // With the FIFO empty no requester owns the beat, so RREADY stays low and it waits.
  assign m_axi_gmem_RREADY = ~w_fifo_empty & (w_fifo_head ? s1_RREADY : s0_RREADY);
  assign w_r_pop           = m_axi_gmem_RVALID & m_axi_gmem_RREADY & m_axi_gmem_RLAST;

  assign s0_RVALID = m_axi_gmem_RVALID & ~w_fifo_empty & ~w_fifo_head;
  assign s1_RVALID = m_axi_gmem_RVALID & ~w_fifo_empty &  w_fifo_head;

  assign s0_RDATA = m_axi_gmem_RDATA;
  assign s0_RRESP = m_axi_gmem_RRESP;
  assign s0_RLAST = m_axi_gmem_RLAST;
  assign s1_RDATA = m_axi_gmem_RDATA;
  assign s1_RRESP = m_axi_gmem_RRESP;
  assign s1_RLAST = m_axi_gmem_RLAST;

  assign busy = (w_fifo_count != '0) | m_axi_gmem_ARVALID;

endmodule

// File: tb/tb_sda_gmem_read_arbiter.sv
// Self-checking bench for sda_gmem_read_arbiter: directed scenarios then random traffic,
// every cycle compared against a transaction-level model (owner queue + round-robin rule).
module tb_sda_gmem_read_arbiter;

  localparam int ORDER_DEPTH = 4;

  logic        ap_clk;
  logic        ap_rst_n;
  logic [63:0] s0_ARADDR, s1_ARADDR;
  logic [7:0]  s0_ARLEN, s1_ARLEN;
  logic        s0_ARVALID, s1_ARVALID, s0_ARREADY, s1_ARREADY;
  logic [31:0] s0_RDATA, s1_RDATA;
  logic [1:0]  s0_RRESP, s1_RRESP;
  logic        s0_RLAST, s1_RLAST, s0_RVALID, s1_RVALID, s0_RREADY, s1_RREADY;
  logic [63:0] m_axi_gmem_ARADDR;
  logic [7:0]  m_axi_gmem_ARLEN;
  logic        m_axi_gmem_ARVALID, m_axi_gmem_ARREADY;
  logic [31:0] m_axi_gmem_RDATA;
  logic [1:0]  m_axi_gmem_RRESP;
  logic        m_axi_gmem_RLAST, m_axi_gmem_RVALID, m_axi_gmem_RREADY;
  logic        busy;

  sda_gmem_read_arbiter #(
    .ADDR_WIDTH (64),
    .DATA_WIDTH (32),
    .ORDER_DEPTH(ORDER_DEPTH)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s0_ARADDR(s0_ARADDR), .s0_ARLEN(s0_ARLEN), .s0_ARVALID(s0_ARVALID), .s0_ARREADY(s0_ARREADY),
    .s0_RDATA(s0_RDATA), .s0_RRESP(s0_RRESP), .s0_RLAST(s0_RLAST), .s0_RVALID(s0_RVALID),
    .s0_RREADY(s0_RREADY),
    .s1_ARADDR(s1_ARADDR), .s1_ARLEN(s1_ARLEN), .s1_ARVALID(s1_ARVALID), .s1_ARREADY(s1_ARREADY),
    .s1_RDATA(s1_RDATA), .s1_RRESP(s1_RRESP), .s1_RLAST(s1_RLAST), .s1_RVALID(s1_RVALID),
    .s1_RREADY(s1_RREADY),
    .m_axi_gmem_ARADDR(m_axi_gmem_ARADDR), .m_axi_gmem_ARLEN(m_axi_gmem_ARLEN),
    .m_axi_gmem_ARVALID(m_axi_gmem_ARVALID), .m_axi_gmem_ARREADY(m_axi_gmem_ARREADY),
    .m_axi_gmem_RDATA(m_axi_gmem_RDATA), .m_axi_gmem_RRESP(m_axi_gmem_RRESP),
    .m_axi_gmem_RLAST(m_axi_gmem_RLAST), .m_axi_gmem_RVALID(m_axi_gmem_RVALID),
    .m_axi_gmem_RREADY(m_axi_gmem_RREADY),
    .busy(busy)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pending AR (if any), round-robin memory, queue of burst owners.
  bit          m_issue;
  logic [63:0] m_addr;
  logic [7:0]  m_len;
  bit          m_last;
  int          q_own[$];
  int          mq_len[$];
  int          beat_cnt;

  // Observations taken from DUT handshakes.
  int dut_acc[$];
  int obs_beat_log[$];
  int obs_beats[2];
  int obs_acc_last;

  logic [63:0] saved_addr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    m_issue  = 1'b0;
    m_addr   = '0;
    m_len    = '0;
    m_last   = 1'b1;
    q_own.delete();
    mq_len.delete();
    beat_cnt = 0;
    dut_acc.delete();
    obs_beat_log.delete();
    obs_beats[0] = 0;
    obs_beats[1] = 0;
    obs_acc_last = -1;
  endtask

  task automatic clear_inputs();
    s0_ARVALID = 1'b0; s1_ARVALID = 1'b0;
    s0_ARADDR = '0; s1_ARADDR = '0; s0_ARLEN = '0; s1_ARLEN = '0;
    s0_RREADY = 1'b0; s1_RREADY = 1'b0;
    m_axi_gmem_ARREADY = 1'b0;
    m_axi_gmem_RVALID = 1'b0; m_axi_gmem_RLAST = 1'b0;
    m_axi_gmem_RDATA = '0; m_axi_gmem_RRESP = '0;
  endtask

  // Called at posedge+1; returns at posedge+1 of the following cycle.
  task automatic do_reset();
    #2;
    ap_rst_n = 1'b0;
    clear_inputs();
    reset_model();
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
  endtask

  // Master-side R generator: offers the next beat of the oldest issued burst.
  task automatic gen_r(input int prob);
    if (!m_axi_gmem_RVALID && mq_len.size() > 0 && $urandom_range(99) < prob) begin
      m_axi_gmem_RVALID = 1'b1;
      m_axi_gmem_RDATA  = $urandom;
      m_axi_gmem_RRESP  = 2'($urandom_range(3));
      m_axi_gmem_RLAST  = (beat_cnt == mq_len[0]);
    end
  endtask

  // One clock: compare every output with the model, then advance the model.
  task automatic step();
    bit full, empty, acc, arhs, beat, pop;
    int head, grant;
    bit e_rdy0, e_rdy1, e_rready;
    #1;
    full  = (q_own.size() == ORDER_DEPTH);
    empty = (q_own.size() == 0);
    head  = empty ? 0 : q_own[0];
    if (s0_ARVALID && s1_ARVALID) grant = m_last ? 0 : 1;
    else                          grant = s1_ARVALID ? 1 : 0;
    acc      = !m_issue && !full && (s0_ARVALID || s1_ARVALID);
    e_rdy0   = acc && (grant == 0);
    e_rdy1   = acc && (grant == 1);
    e_rready = !empty && ((head == 0) ? s0_RREADY : s1_RREADY);

    check("s0_arready", 64'(s0_ARREADY), 64'(e_rdy0));
    check("s1_arready", 64'(s1_ARREADY), 64'(e_rdy1));
    check("m_arvalid", 64'(m_axi_gmem_ARVALID), 64'(m_issue));
    check("m_araddr", m_axi_gmem_ARADDR, m_addr);
    check("m_arlen", 64'(m_axi_gmem_ARLEN), 64'(m_len));
    check("s0_rvalid", 64'(s0_RVALID), 64'(m_axi_gmem_RVALID && !empty && head == 0));
    check("s1_rvalid", 64'(s1_RVALID), 64'(m_axi_gmem_RVALID && !empty && head == 1));
    check("m_rready", 64'(m_axi_gmem_RREADY), 64'(e_rready));
    check("busy", 64'(busy), 64'(!empty || m_issue));
    if (m_axi_gmem_RVALID) begin
      check("s0_rdata", 64'(s0_RDATA), 64'(m_axi_gmem_RDATA));
      check("s1_rdata", 64'(s1_RDATA), 64'(m_axi_gmem_RDATA));
      check("s0_rresp", 64'(s0_RRESP), 64'(m_axi_gmem_RRESP));
      check("s1_rlast", 64'(s1_RLAST), 64'(m_axi_gmem_RLAST));
    end

    obs_acc_last = -1;
    if (s0_ARVALID && s0_ARREADY) begin dut_acc.push_back(0); obs_acc_last = 0; end
    else if (s1_ARVALID && s1_ARREADY) begin dut_acc.push_back(1); obs_acc_last = 1; end
    if (s0_RVALID && s0_RREADY) begin
      obs_beats[0]++;
      if (s0_RLAST) obs_beat_log.push_back(0);
    end
    if (s1_RVALID && s1_RREADY) begin
      obs_beats[1]++;
      if (s1_RLAST) obs_beat_log.push_back(1);
    end

    arhs = m_issue && m_axi_gmem_ARREADY;
    beat = m_axi_gmem_RVALID && e_rready;
    pop  = beat && m_axi_gmem_RLAST;

    @(posedge ap_clk);
    #1;
    if (pop) void'(q_own.pop_front());
    if (arhs) begin
      mq_len.push_back(int'(m_len));
      m_issue = 1'b0;
    end
    if (acc) begin
      q_own.push_back(grant);
      m_issue = 1'b1;
      m_addr  = (grant == 1) ? s1_ARADDR : s0_ARADDR;
      m_len   = (grant == 1) ? s1_ARLEN : s0_ARLEN;
      m_last  = (grant == 1);
    end
    if (beat) begin
      if (m_axi_gmem_RLAST) begin
        if (mq_len.size() > 0) void'(mq_len.pop_front());
        beat_cnt = 0;
      end else begin
        beat_cnt++;
      end
      m_axi_gmem_RVALID = 1'b0;
      m_axi_gmem_RLAST  = 1'b0;
    end
  endtask

  initial begin
    clear_inputs();
    reset_model();
    ap_rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_arvalid", 64'(m_axi_gmem_ARVALID), 64'd0);
    check("rst_araddr", m_axi_gmem_ARADDR, 64'd0);
    @(posedge ap_clk);
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;

    // Idle after reset, then a beat offered with nothing outstanding.
    step();
    m_axi_gmem_RVALID = 1'b1;
    m_axi_gmem_RDATA  = 32'hCAFE_0001;
    s0_RREADY = 1'b1;
    s1_RREADY = 1'b1;
    #1;
    check("empty_rready", 64'(m_axi_gmem_RREADY), 64'd0);
    step();
    m_axi_gmem_RVALID = 1'b0;
    s1_RREADY = 1'b0;

    // Single request from s0, four beats back.
    s0_ARADDR = 64'h1000;
    s0_ARLEN  = 8'd3;
    s0_ARVALID = 1'b1;
    m_axi_gmem_ARREADY = 1'b1;
    step();
    s0_ARVALID = 1'b0;
    #1;
    check("single_arvalid", 64'(m_axi_gmem_ARVALID), 64'd1);
    check("single_araddr", m_axi_gmem_ARADDR, 64'h1000);
    check("single_arlen", 64'(m_axi_gmem_ARLEN), 64'd3);
    step();
    repeat (4) begin
      gen_r(100);
      step();
    end
    check("single_beats", 64'(obs_beats[0]), 64'd4);
    check("single_busy_end", 64'(busy), 64'd0);
    step();

    // Contention from reset: grants must alternate starting with s0.
    do_reset();
    s0_ARVALID = 1'b1;
    s1_ARVALID = 1'b1;
    m_axi_gmem_ARREADY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s0_ARADDR = {$urandom, $urandom};
      s1_ARADDR = {$urandom, $urandom};
      step();
    end
    s0_ARVALID = 1'b0;
    s1_ARVALID = 1'b0;
    check("rr_count", 64'(dut_acc.size()), 64'd4);
    if (dut_acc.size() == 4) begin
      for (int i = 0; i < 4; i++) check("rr_order", 64'(dut_acc[i]), 64'(i % 2));
    end
    s0_RREADY = 1'b1;
    s1_RREADY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      gen_r(100);
      step();
    end
    check("rr_return_count", 64'(obs_beat_log.size()), 64'd4);
    if (obs_beat_log.size() == 4) begin
      for (int i = 0; i < 4; i++) check("rr_return_order", 64'(obs_beat_log[i]), 64'(i % 2));
    end

    // Order FIFO full: four accepted, fifth held until the first RLAST pop.
    do_reset();
    m_axi_gmem_ARREADY = 1'b1;
    s0_ARVALID = 1'b1;
    s0_ARLEN   = 8'd0;
    repeat (10) step();
    check("full_accepts", 64'(dut_acc.size()), 64'd4);
    repeat (3) begin
      #1;
      check("full_blocked", 64'(s0_ARREADY), 64'd0);
      step();
    end
    s0_RREADY = 1'b1;
    gen_r(100);
    #1;
    check("full_pop_cycle", 64'(s0_ARREADY), 64'd0);
    step();
    #1;
    check("full_resume", 64'(s0_ARREADY), 64'd1);
    step();
    check("full_accepts_after", 64'(dut_acc.size()), 64'd5);
    s0_ARVALID = 1'b0;

    // AR backpressure, then R backpressure from s1.
    do_reset();
    saved_addr = 64'hDEAD_BEEF_0000_0040;
    s1_ARADDR  = saved_addr;
    s1_ARLEN   = 8'd2;
    s1_ARVALID = 1'b1;
    step();
    s0_ARVALID = 1'b1;
    s0_ARADDR  = 64'h2000;
    s1_ARADDR  = 64'h3000;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_arvalid", 64'(m_axi_gmem_ARVALID), 64'd1);
      check("bp_araddr", m_axi_gmem_ARADDR, saved_addr);
    end
    s0_ARVALID = 1'b0;
    s1_ARVALID = 1'b0;
    m_axi_gmem_ARREADY = 1'b1;
    step();
    s0_RREADY = 1'b1;
    s1_RREADY = 1'b0;
    gen_r(100);
    repeat (4) step();
    check("bp_rready_low", 64'(m_axi_gmem_RREADY), 64'd0);
    s1_RREADY = 1'b1;
    repeat (4) begin
      gen_r(100);
      step();
    end
    check("bp_beats", 64'(obs_beats[1]), 64'd3);

    // Push and pop on the same cycle keep the count: head moves to the new owner.
    do_reset();
    m_axi_gmem_ARREADY = 1'b1;
    s1_ARVALID = 1'b1;
    s1_ARLEN   = 8'd0;
    step();
    s1_ARVALID = 1'b0;
    step();
    s0_ARVALID = 1'b1;
    s0_ARLEN   = 8'd0;
    s0_RREADY  = 1'b1;
    s1_RREADY  = 1'b1;
    gen_r(100);
    #1;
    check("pp_arready", 64'(s0_ARREADY), 64'd1);
    check("pp_rready", 64'(m_axi_gmem_RREADY), 64'd1);
    step();
    s0_ARVALID = 1'b0;
    step();
    check("pp_busy", 64'(busy), 64'd1);
    gen_r(100);
    #1;
    check("pp_head_s0", 64'(s0_RVALID), 64'd1);
    step();
    step();

    // Asynchronous reset in the middle of a burst.
    m_axi_gmem_ARREADY = 1'b0;
    s0_ARVALID = 1'b1;
    s0_ARADDR  = 64'h4000;
    s0_ARLEN   = 8'd3;
    step();
    s1_ARVALID = 1'b1;
    m_axi_gmem_RVALID = 1'b1;
    m_axi_gmem_RLAST  = 1'b0;
    #1;
    check("mid_arvalid_pre", 64'(m_axi_gmem_ARVALID), 64'd1);
    check("mid_rvalid_pre", 64'(s0_RVALID), 64'd1);
    #1;
    ap_rst_n = 1'b0;
    #1;
    check("mid_arvalid", 64'(m_axi_gmem_ARVALID), 64'd0);
    check("mid_s0_arready", 64'(s0_ARREADY), 64'd0);
    check("mid_s1_arready", 64'(s1_ARREADY), 64'd0);
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_araddr", m_axi_gmem_ARADDR, 64'd0);
    check("mid_arlen", 64'(m_axi_gmem_ARLEN), 64'd0);
    check("mid_s0_rvalid", 64'(s0_RVALID), 64'd0);
    check("mid_s1_rvalid", 64'(s1_RVALID), 64'd0);
    check("mid_rready", 64'(m_axi_gmem_RREADY), 64'd0);
    reset_model();
    m_axi_gmem_RVALID = 1'b0;
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    step();
    check("post_rst_grant", 64'(dut_acc.size() == 1 && dut_acc[0] == 0), 64'd1);
    s0_ARVALID = 1'b0;
    s1_ARVALID = 1'b0;
    m_axi_gmem_ARREADY = 1'b1;
    s0_RREADY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      gen_r(100);
      step();
    end

    // Random traffic on both sides.
    for (int i = 0; i < 600; i++) begin
      if (!s0_ARVALID || obs_acc_last == 0) begin
        s0_ARVALID = ($urandom_range(2) == 0);
        s0_ARADDR  = {$urandom, $urandom};
        s0_ARLEN   = 8'($urandom_range(3));
      end
      if (!s1_ARVALID || obs_acc_last == 1) begin
        s1_ARVALID = ($urandom_range(2) == 0);
        s1_ARADDR  = {$urandom, $urandom};
        s1_ARLEN   = 8'($urandom_range(3));
      end
      m_axi_gmem_ARREADY = ($urandom_range(3) != 0);
      s0_RREADY = ($urandom_range(3) != 0);
      s1_RREADY = ($urandom_range(3) != 0);
      gen_r(50);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
